// File: rtl/phy_tx_mutex_arbiter_if.sv
// ---------------------------------------------------------------------------
// phy_tx_mutex_arbiter_if
// Bundle of the PHY-TX port mutex request/grant signals.
//   req_i          requester r port mask at [r*NPORT +: NPORT]
//   val_o          granted mask per requester, same packing as req_i
//   port_busy_o    port p currently owned
//   port_owner_o   owner id of port p at [p*IDW +: IDW], 0 when free
//   timeout_flag_o sticky force-revoke flag per requester
//   flag_clr_i     write-1-to-clear for timeout_flag_o
// master: requester side. slave: the arbiter.
// ---------------------------------------------------------------------------
interface phy_tx_mutex_arbiter_if #(
    parameter int NREQ  = 5,
    parameter int NPORT = 4,
    parameter int IDW   = 3
);
    logic [NREQ*NPORT-1:0] req_i;
    logic [NREQ*NPORT-1:0] val_o;
    logic [NPORT-1:0]      port_busy_o;
    logic [NPORT*IDW-1:0]  port_owner_o;
    logic [NREQ-1:0]       timeout_flag_o;
    logic [NREQ-1:0]       flag_clr_i;

    modport master (
        output req_i,
        output flag_clr_i,
        input  val_o,
        input  port_busy_o,
        input  port_owner_o,
        input  timeout_flag_o
    );

    modport slave (
        input  req_i,
        input  flag_clr_i,
        output val_o,
        output port_busy_o,
        output port_owner_o,
        output timeout_flag_o
    );
endinterface

// File: rtl/phy_tx_mutex_arbiter.sv
// ---------------------------------------------------------------------------
// phy_tx_mutex_arbiter
// Owns the PHY-TX FIFO write ports and grants port sets atomically to NREQ
// requesters. Round-robin with head reservation: the first pending requester
// from the pointer reserves its mask so later single-port requesters cannot
// keep stealing ports a multi-port requester is waiting for.
// Ports:
//   clk     clock
//   arst_n  asynchronous reset, active-low
//   bus     phy_tx_mutex_arbiter_if.slave (req_i, val_o, port_busy_o,
//           port_owner_o, timeout_flag_o, flag_clr_i)
// Optional feature: define MUTEX_TIMEOUT_EN to enable per-requester hold
// counters with forced revoke after TIMEOUT held cycles, sticky timeout
// flags and a lock that holds until the requester drops its request.
// ---------------------------------------------------------------------------
module phy_tx_mutex_arbiter #(
    parameter int NREQ    = 5,
    parameter int NPORT   = 4,
    parameter int IDW     = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   arst_n,
    phy_tx_mutex_arbiter_if.slave  bus
);

    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Registered state
    logic [NPORT-1:0] val_q   [NREQ];
    logic [NPORT-1:0] val_d   [NREQ];
    logic [NREQ-1:0]  hold_q, hold_d;
    logic [NPORT-1:0] busy_q, busy_d;
    logic [IDW-1:0]   owner_q [NPORT];
    logic [IDW-1:0]   owner_d [NPORT];
    logic [RRW-1:0]   rr_q, rr_d;

    // Arbitration results
    logic [NPORT-1:0] req_s [NREQ];
    logic [NREQ-1:0]  pending_s;
    logic [NREQ-1:0]  eligible_s;
    logic [NPORT-1:0] head_mask_s;
    logic             grant_vld_s;
    logic [RRW-1:0]   grant_idx_s;
    logic [NPORT-1:0] grant_mask_s;
    logic [RRW-1:0]   rr_next_s;
    logic [NREQ-1:0]  lock_s;

`ifdef MUTEX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0]   cnt_q [NREQ];
    logic [CW-1:0]   cnt_d [NREQ];
    logic [NREQ-1:0] lock_q, lock_d;
    logic [NREQ-1:0] flag_q, flag_d;

    assign lock_s = lock_q;
`else
    logic unused_s;

    assign lock_s   = {NREQ{1'b0}};
    assign unused_s = (^bus.flag_clr_i) ^ (TIMEOUT == 0);
`endif

    // Decode requests, locate the head and pick at most one grantee
    always_comb begin : arb_comb
        logic [RRW:0]   sum;
        logic [RRW-1:0] idx;
        logic [RRW-1:0] head_idx;
        logic           head_found;
        logic           grant_found;
        logic           take;

        sum         = {(RRW+1){1'b0}};
        idx         = {RRW{1'b0}};
        head_idx    = {RRW{1'b0}};
        head_found  = 1'b0;
        grant_found = 1'b0;
        take        = 1'b0;
        grant_idx_s = {RRW{1'b0}};

        for (int r = 0; r < NREQ; r++) begin
            req_s[r]     = bus.req_i[r*NPORT +: NPORT];
            pending_s[r] = (req_s[r] != {NPORT{1'b0}}) && !hold_q[r] && !lock_s[r];
        end

        // Head: first pending requester scanning upward from the pointer
        for (int k = 0; k < NREQ; k++) begin
            sum        = {1'b0, rr_q} + (RRW+1)'(k);
            idx        = (sum >= (RRW+1)'(NREQ)) ? RRW'(sum - (RRW+1)'(NREQ)) : sum[RRW-1:0];
            take       = !head_found && pending_s[idx];
            head_idx   = take ? idx : head_idx;
            head_found = head_found | take;
        end
        head_mask_s = head_found ? req_s[head_idx] : {NPORT{1'b0}};

        // Non-head requesters may not touch any port the head is waiting on
        for (int r = 0; r < NREQ; r++) begin
            eligible_s[r] = pending_s[r]
                         && ((req_s[r] & busy_q) == {NPORT{1'b0}})
                         && ((head_idx == RRW'(r)) || ((req_s[r] & head_mask_s) == {NPORT{1'b0}}));
        end

        for (int k = 0; k < NREQ; k++) begin
            sum         = {1'b0, rr_q} + (RRW+1)'(k);
            idx         = (sum >= (RRW+1)'(NREQ)) ? RRW'(sum - (RRW+1)'(NREQ)) : sum[RRW-1:0];
            take        = !grant_found && eligible_s[idx];
            grant_idx_s = take ? idx : grant_idx_s;
            grant_found = grant_found | take;
        end

        grant_vld_s  = grant_found;
        grant_mask_s = grant_found ? req_s[grant_idx_s] : {NPORT{1'b0}};
        rr_next_s    = (grant_idx_s == RRW'(NREQ - 1)) ? {RRW{1'b0}} : grant_idx_s + RRW'(1);
    end

    // Next-state: releases (and revokes) first, then the single new grant
    always_comb begin : next_comb
        logic [NPORT-1:0] free_mask;
        logic [NREQ-1:0]  revoke;

        val_d     = val_q;
        hold_d    = hold_q;
        busy_d    = busy_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        free_mask = {NPORT{1'b0}};
        revoke    = {NREQ{1'b0}};
`ifdef MUTEX_TIMEOUT_EN
        cnt_d  = cnt_q;
        lock_d = lock_q;
        flag_d = flag_q;
`endif

        for (int r = 0; r < NREQ; r++) begin
`ifdef MUTEX_TIMEOUT_EN
            // Lock survives until the requester has dropped its request
            if (lock_q[r] && (req_s[r] == {NPORT{1'b0}})) begin
                lock_d[r] = 1'b0;
            end else begin
                lock_d[r] = lock_q[r];
            end
`endif
            if (hold_q[r] && (req_s[r] == {NPORT{1'b0}})) begin
                hold_d[r] = 1'b0;
                val_d[r]  = {NPORT{1'b0}};
                free_mask = free_mask | val_q[r];
            end
`ifdef MUTEX_TIMEOUT_EN
            else if (hold_q[r] && (cnt_q[r] == CW'(TIMEOUT - 1))) begin
                hold_d[r] = 1'b0;
                val_d[r]  = {NPORT{1'b0}};
                free_mask = free_mask | val_q[r];
                cnt_d[r]  = CW'(TIMEOUT);
                lock_d[r] = 1'b1;
                revoke[r] = 1'b1;
            end else if (hold_q[r]) begin
                cnt_d[r] = cnt_q[r] + CW'(1);
            end
`endif
            else begin
                hold_d[r] = hold_q[r];
            end
`ifdef MUTEX_TIMEOUT_EN
            // Set has priority over a same-cycle clear
            if (revoke[r]) begin
                flag_d[r] = 1'b1;
            end else if (bus.flag_clr_i[r]) begin
                flag_d[r] = 1'b0;
            end else begin
                flag_d[r] = flag_q[r];
            end
`endif
        end

        busy_d = busy_q & ~free_mask;
        for (int p = 0; p < NPORT; p++) begin
            if (free_mask[p]) begin
                owner_d[p] = {IDW{1'b0}};
            end else begin
                owner_d[p] = owner_q[p];
            end
        end

        // Grant only looked at busy_q, so ports freed this cycle stay unused
        if (grant_vld_s) begin
            for (int p = 0; p < NPORT; p++) begin
                if (grant_mask_s[p]) begin
                    busy_d[p]  = 1'b1;
                    owner_d[p] = IDW'(grant_idx_s);
                end else begin
                    busy_d[p]  = busy_d[p];
                end
            end
            hold_d[grant_idx_s] = 1'b1;
            val_d[grant_idx_s]  = grant_mask_s;
            rr_d                = rr_next_s;
`ifdef MUTEX_TIMEOUT_EN
            cnt_d[grant_idx_s]  = {CW{1'b0}};
`endif
        end else begin
            rr_d = rr_q;
        end
    end

    // Core arbitration state registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            val_q   <= '{default: {NPORT{1'b0}}};
            hold_q  <= {NREQ{1'b0}};
            busy_q  <= {NPORT{1'b0}};
            owner_q <= '{default: {IDW{1'b0}}};
            rr_q    <= {RRW{1'b0}};
        end else begin
            val_q   <= val_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

`ifdef MUTEX_TIMEOUT_EN
    // Hold counters, locks and sticky timeout flags
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q  <= '{default: {CW{1'b0}}};
            lock_q <= {NREQ{1'b0}};
            flag_q <= {NREQ{1'b0}};
        end else begin
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
            flag_q <= flag_d;
        end
    end

    assign bus.timeout_flag_o = flag_q;
`else
    assign bus.timeout_flag_o = {NREQ{1'b0}};
`endif

    assign bus.port_busy_o = busy_q;

    for (genvar g = 0; g < NREQ; g++) begin : g_val
        assign bus.val_o[g*NPORT +: NPORT] = val_q[g];
    end

    for (genvar g = 0; g < NPORT; g++) begin : g_owner
        assign bus.port_owner_o[g*IDW +: IDW] = owner_q[g];
    end

endmodule
